restador_n: RTL and testbench

- Parameterised N-bit down-counter ("restador") driven by a push-button request.
- On reset, the counter loads an externally supplied start value.
- Each new press of the subtract button then decrements the held value by exactly one.
- Used in lab top-levels between the board switches/buttons and display decoding; instantiated at several widths (2, 4, 6 bits) in one design.

---
 rtl/restador_pkg.sv | 15 +
 rtl/restador_edge_detect.sv | 21 ++
 rtl/restador_n.sv | 36 +++
 tb/tb_restador_n.sv | 122 ++++++++++++
 4 files changed

// File: rtl/restador_pkg.sv
// Shared constants and the modulo decrement used by the restador counter and its model.
package restador_pkg;

  localparam int RESTADOR_DEFAULT_N = 4;

  // Decrement modulo 2^width; width is 1..32, so the mask is built in 33 bits.
  function automatic logic [31:0] dec_wrap(input logic [31:0] value, input int unsigned width);
    logic [32:0] mask;
    logic [32:0] diff;
    mask = (33'd1 << width) - 33'd1;
    diff = {1'b0, value} - 33'd1;
    return 32'(diff & mask);
  endfunction

endpackage

// File: rtl/restador_edge_detect.sv
// Rising-edge detector: one-cycle pulse when level_in goes from a low sample to high.
module restador_edge_detect
  import restador_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst) r_q <= 1'b0;
    else      r_q <= level_in;
  end

  // Clearing r_q in reset makes a button held through reset count once afterwards.
  assign pulse_out = level_in & ~r_q;

endmodule

// File: rtl/restador_n.sv
// N-bit down-counter: loads data_in on reset, decrements once per button press.
module restador_n
  import restador_pkg::*;
#(
  parameter int N = RESTADOR_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_sub,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out
);

  logic [N-1:0] r_cnt;
  logic         w_press;
  logic [31:0]  w_dec_full;
  logic [N-1:0] w_dec;

  restador_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .level_in  (btn_sub),
    .pulse_out (w_press)
  );

  assign w_dec_full = dec_wrap(32'(r_cnt), N);
  assign w_dec      = w_dec_full[N-1:0];

  always_ff @(posedge clk) begin
    if (!rst)         r_cnt <= data_in;
    else if (w_press) r_cnt <= w_dec;
  end

  assign data_out = r_cnt;

endmodule

// File: tb/tb_restador_n.sv
// Directed scoreboard bench for restador_n at widths 2, 4 and 6.
module tb_restador_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2 = 1'b1, btn2 = 1'b0;
  logic [1:0] din2 = '0, dout2;
  logic       rst4 = 1'b1, btn4 = 1'b0;
  logic [3:0] din4 = '0, dout4;
  logic       rst6 = 1'b1, btn6 = 1'b0;
  logic [5:0] din6 = '0, dout6;

  restador_n #(.N(2)) u_n2 (.clk(clk), .rst(rst2), .btn_sub(btn2), .data_in(din2), .data_out(dout2));
  restador_n #(.N(4)) u_n4 (.clk(clk), .rst(rst4), .btn_sub(btn4), .data_in(din4), .data_out(dout4));
  restador_n #(.N(6)) u_n6 (.clk(clk), .rst(rst6), .btn_sub(btn6), .data_in(din6), .data_out(dout6));

  typedef struct {
    int         sel;
    logic [5:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Drive one cycle on the selected instance, then check its output after the edge.
  task automatic cyc(input int sel, input logic r, input logic b, input logic [5:0] d,
                     input logic [5:0] e, input string tag);
    exp_t       it;
    logic [5:0] obs;
    case (sel)
      2:       begin rst2 = r; btn2 = b; din2 = d[1:0]; end
      4:       begin rst4 = r; btn4 = b; din4 = d[3:0]; end
      default: begin rst6 = r; btn6 = b; din6 = d;      end
    endcase
    it.sel = sel; it.exp = e; it.tag = tag;
    sb.push_back(it);
    @(posedge clk);
    #1;
    it = sb.pop_front();
    case (it.sel)
      2:       obs = {4'b0, dout2};
      4:       obs = {2'b0, dout4};
      default: obs = dout6;
    endcase
    total++;
    assert (obs === it.exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
    end
  endtask

  initial begin
    @(posedge clk); #1;

    // N=2
    cyc(2, 0, 0, 3, 3, "n2_reset");
    cyc(2, 1, 1, 3, 2, "n2_press1");
    cyc(2, 1, 0, 3, 2, "n2_release1");
    cyc(2, 1, 1, 3, 1, "n2_press2");
    cyc(2, 1, 0, 3, 1, "n2_release2");
    cyc(2, 0, 0, 3, 3, "n2_reset2");
    cyc(2, 0, 0, 0, 0, "n2_reset_zero");
    cyc(2, 1, 1, 0, 3, "n2_wrap");
    cyc(2, 1, 0, 0, 3, "n2_wrap_hold");

    // N=4, including reset tracking data_in
    cyc(4, 0, 0, 7, 7, "n4_reset_track_a");
    cyc(4, 0, 0, 13, 13, "n4_reset_track_b");
    cyc(4, 1, 1, 13, 12, "n4_press1");
    cyc(4, 1, 0, 13, 12, "n4_release1");
    cyc(4, 1, 1, 13, 11, "n4_press2");
    cyc(4, 1, 0, 13, 11, "n4_release2");
    cyc(4, 0, 0, 13, 13, "n4_reset2");

    // N=6
    cyc(6, 0, 0, 47, 47, "n6_reset");
    cyc(6, 1, 1, 47, 46, "n6_press1");
    cyc(6, 1, 0, 47, 46, "n6_release1");
    cyc(6, 1, 1, 47, 45, "n6_press2");
    cyc(6, 1, 0, 47, 45, "n6_release2");
    cyc(6, 0, 0, 47, 47, "n6_reset2");

    // N=4 wrap from zero
    cyc(4, 0, 0, 0, 0, "wrap_reset");
    cyc(4, 1, 1, 0, 15, "wrap_press");
    cyc(4, 1, 0, 0, 15, "wrap_release");
    cyc(4, 1, 1, 0, 14, "wrap_press2");
    cyc(4, 1, 0, 0, 14, "wrap_release2");

    // N=4 held button counts once
    cyc(4, 0, 0, 9, 9, "hold_reset");
    for (int k = 0; k < 5; k++) cyc(4, 1, 1, 9, 8, "hold_high");
    cyc(4, 1, 0, 9, 8, "hold_release");
    cyc(4, 1, 1, 9, 7, "hold_repress");
    cyc(4, 1, 0, 9, 7, "hold_repress_rel");

    // N=4 reset beats a simultaneous press; held button counts once afterwards
    cyc(4, 0, 1, 5, 5, "rstwin_reset");
    cyc(4, 0, 1, 5, 5, "rstwin_reset_held");
    cyc(4, 1, 1, 5, 4, "rstwin_first");
    cyc(4, 1, 1, 5, 4, "rstwin_held");
    cyc(4, 1, 0, 5, 4, "rstwin_release");

    // idle instances must not have moved
    cyc(2, 1, 0, 0, 3, "n2_idle");
    cyc(6, 1, 0, 47, 47, "n6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
